// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/bubble sequencing for the LC-3 IF/ID/EX/WB pipeline.
// Define PIPE_CTRL_PERF_EN to add saturating stall/bubble cycle counters.
module pipe_ctrl #(
    parameter int REDIR_BUBBLES = 2,
    parameter int TMO_W = 8
) (
    input  logic       clk_i_w,
    input  logic       rst_i_w,
    output logic       imem_req_o_w,
    input  logic       imem_ack_i_w,
    input  logic       dmem_req_i_w,
    input  logic       dmem_ack_i_w,
    input  logic       ld_ex_i_w,
    input  logic [2:0] ex_dr_i_w,
    input  logic [2:0] id_sr1_i_w,
    input  logic [2:0] id_sr2_i_w,
    input  logic [1:0] id_sr_use_i_w,
    input  logic       br_taken_i_w,
    input  logic       halt_i_w,
    input  logic       resume_i_w,
    output logic [3:0] stall_o_w,
    output logic [3:0] bubble_o_w,
    output logic       pc_sel_o_w,
    output logic [2:0] state_o_r,
    output logic       tmo_o_r
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [15:0] stall_cnt_o_r,
    output logic [15:0] bubble_cnt_o_r
`endif
);
    typedef enum logic [2:0] {RUN = 3'd0, MEMWAIT = 3'd1, REDIR = 3'd2, HALTED = 3'd3, ERR = 3'd4} state_t;
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    state_t state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0] rcnt;
    logic lu_done, eval, dwait, mwait, lu_hit, fwait;
    assign state_o_r = state;
    // An acked MEMWAIT cycle is resolved like RUN, so a held branch is taken then.
    assign eval = state == RUN || (state == MEMWAIT && dmem_ack_i_w);
    assign dwait = state == RUN && dmem_req_i_w && !dmem_ack_i_w;
    assign mwait = state == MEMWAIT && !dmem_ack_i_w;
    assign lu_hit = ld_ex_i_w && !lu_done &&
                    ((id_sr_use_i_w[0] && id_sr1_i_w == ex_dr_i_w) ||
                     (id_sr_use_i_w[1] && id_sr2_i_w == ex_dr_i_w));
    assign fwait = state == RUN && !imem_ack_i_w;
    always_comb begin
        stall_o_w = '0;
        bubble_o_w = '0;
        pc_sel_o_w = 1'b0;
        imem_req_o_w = !rst_i_w && (state == RUN || state == REDIR);
        if (rst_i_w) bubble_o_w = 4'b1111;
        else if (dwait || mwait) begin
            stall_o_w = 4'b0111;
            bubble_o_w = 4'b1000;
        end
        else if (eval && br_taken_i_w) begin
            pc_sel_o_w = 1'b1;
            bubble_o_w = 4'b0011;
        end
        else if (eval && halt_i_w) bubble_o_w = 4'b0011;
        else if (eval && lu_hit) begin
            stall_o_w = 4'b0011;
            bubble_o_w = 4'b0100;
        end
        else if (fwait) begin
            stall_o_w = 4'b0001;
            bubble_o_w = 4'b0010;
        end
        else if (state == REDIR) bubble_o_w = 4'b0011;
        else if (state == HALTED) bubble_o_w = 4'b0111;
        else if (state == ERR) bubble_o_w = 4'b1111;
    end
    always_ff @(posedge clk_i_w) begin
        if (rst_i_w) begin
            state <= RUN;
            tmo_cnt <= '0;
            rcnt <= '0;
            lu_done <= 1'b0;
            tmo_o_r <= 1'b0;
        end
        else begin
            // A load-use stall lasts one cycle even if the hazard inputs stay up.
            lu_done <= stall_o_w == 4'b0011;
            if (dwait) begin
                state <= MEMWAIT;
                tmo_cnt <= {{(TMO_W-1){1'b0}}, 1'b1};
            end
            else if (mwait) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_LAST) begin
                    state <= ERR;
                    tmo_o_r <= 1'b1;
                end
            end
            else if (eval) begin
                tmo_cnt <= '0;
                state <= br_taken_i_w ? (REDIR_BUBBLES > 1 ? REDIR : RUN) : halt_i_w ? HALTED : RUN;
                if (br_taken_i_w) rcnt <= 2'(REDIR_BUBBLES - 1);
            end
            else if (state == REDIR) begin
                rcnt <= rcnt - 2'd1;
                if (rcnt == 2'd1) state <= RUN;
            end
            else if (state == HALTED && resume_i_w) state <= RUN;
        end
    end
`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk_i_w) begin
        if (rst_i_w) begin
            stall_cnt_o_r <= '0;
            bubble_cnt_o_r <= '0;
        end
        else begin
            if (|stall_o_w && !(&stall_cnt_o_r)) stall_cnt_o_r <= stall_cnt_o_r + 16'd1;
            if (|bubble_o_w && (state == RUN || state == REDIR || state == MEMWAIT) && !(&bubble_cnt_o_r))
                bubble_cnt_o_r <= bubble_cnt_o_r + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed per-cycle vectors for pipe_ctrl (REDIR_BUBBLES=2, TMO_W=4).
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst, imem_req, imem_ack, dmem_req, dmem_ack, ld_ex, br_taken, halt, resume, pc_sel, tmo;
    logic [2:0] ex_dr, id_sr1, id_sr2, state;
    logic [1:0] sr_use;
    logic [3:0] stall, bubble;
    int applied = 0;
    int errors = 0;

    typedef struct {
        logic rst, iack, dreq, dack, ld;
        logic [2:0] dr, s1, s2;
        logic [1:0] su;
        logic br, hlt, res;
        logic [3:0] st, bu;
        logic pc, ireq;
        logic [2:0] state;
        logic tmo;
    } vec_t;
    vec_t vecs[$];

    pipe_ctrl #(.REDIR_BUBBLES(2), .TMO_W(4)) dut (
        .clk_i_w(clk), .rst_i_w(rst), .imem_req_o_w(imem_req), .imem_ack_i_w(imem_ack),
        .dmem_req_i_w(dmem_req), .dmem_ack_i_w(dmem_ack), .ld_ex_i_w(ld_ex), .ex_dr_i_w(ex_dr),
        .id_sr1_i_w(id_sr1), .id_sr2_i_w(id_sr2), .id_sr_use_i_w(sr_use), .br_taken_i_w(br_taken),
        .halt_i_w(halt), .resume_i_w(resume), .stall_o_w(stall), .bubble_o_w(bubble),
        .pc_sel_o_w(pc_sel), .state_o_r(state), .tmo_o_r(tmo)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, ia, dq, da, ld, input logic [2:0] dr, s1, s2, input logic [1:0] su,
                       input logic br, hl, rs, input logic [3:0] st, bu, input logic pc, ir,
                       input logic [2:0] sta, input logic tm);
        vecs.push_back('{r, ia, dq, da, ld, dr, s1, s2, su, br, hl, rs, st, bu, pc, ir, sta, tm});
    endtask

    // Drive one cycle, check outputs at the falling edge, then advance past the rising edge.
    task automatic run(input string name, input vec_t v);
        logic [14:0] got, exp;
        rst = v.rst; imem_ack = v.iack; dmem_req = v.dreq; dmem_ack = v.dack; ld_ex = v.ld;
        ex_dr = v.dr; id_sr1 = v.s1; id_sr2 = v.s2; sr_use = v.su;
        br_taken = v.br; halt = v.hlt; resume = v.res;
        @(negedge clk);
        got = {stall, bubble, pc_sel, imem_req, state, tmo};
        exp = {v.st, v.bu, v.pc, v.ireq, v.state, v.tmo};
        applied++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got stall=%b bubble=%b pc_sel=%b imem_req=%b state=%0d tmo=%b, exp stall=%b bubble=%b pc_sel=%b imem_req=%b state=%0d tmo=%b",
                     name, stall, bubble, pc_sel, imem_req, state, tmo, v.st, v.bu, v.pc, v.ireq, v.state, v.tmo);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; imem_ack = 1'b1; dmem_req = 1'b0; dmem_ack = 1'b0; ld_ex = 1'b0;
        ex_dr = 3'd0; id_sr1 = 3'd1; id_sr2 = 3'd2; sr_use = 2'b00;
        br_taken = 1'b0; halt = 1'b0; resume = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        //   rst ia dq da ld dr s1 s2 su     br hl rs  stall    bubble   pc ir st tmo
        repeat (3) add(1, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b1111, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 3, 3, 2, 2'b01, 0, 0, 0, 4'b0011, 4'b0100, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 3, 3, 2, 2'b01, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 5, 1, 5, 2'b10, 0, 0, 0, 4'b0011, 4'b0100, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 5, 5, 5, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0001, 4'b0010, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 1, 0, 0, 4'b0000, 4'b0011, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 1, 0, 0, 4'b0000, 4'b0011, 0, 1, 2, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 3, 3, 2, 2'b01, 1, 0, 0, 4'b0000, 4'b0011, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0011, 0, 1, 2, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0111, 4'b1000, 0, 1, 0, 0);
        repeat (4) add(0, 1, 1, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0111, 4'b1000, 0, 0, 1, 0);
        add(0, 1, 1, 1, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 2, 2'b00, 1, 0, 0, 4'b0111, 4'b1000, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 2, 2'b00, 1, 0, 0, 4'b0111, 4'b1000, 0, 0, 1, 0);
        add(0, 1, 1, 1, 0, 0, 1, 2, 2'b00, 1, 0, 0, 4'b0000, 4'b0011, 1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0011, 0, 1, 2, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 1, 0, 4'b0000, 4'b0011, 0, 1, 0, 0);
        repeat (4) add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0111, 0, 0, 3, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 1, 4'b0000, 4'b0111, 0, 0, 3, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0111, 4'b1000, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0111, 4'b1000, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b1111, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
        foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i]);

        // Timeout: 15 unacknowledged wait cycles, then ERR until reset.
        v = vecs[3];
        v.dreq = 1'b1; v.st = 4'b0111; v.bu = 4'b1000;
        for (int k = 1; k <= 15; k++) begin
            v.state = (k == 1) ? 3'd0 : 3'd1;
            v.ireq = (k == 1);
            run($sformatf("tmo_wait%0d", k), v);
        end
        v.dreq = 1'b0; v.dack = 1'b1; v.br = 1'b1; v.st = 4'b0000; v.bu = 4'b1111;
        v.ireq = 1'b0; v.state = 3'd4; v.tmo = 1'b1;
        for (int k = 0; k < 3; k++) run($sformatf("err_hold%0d", k), v);
        v.rst = 1'b1; v.br = 1'b0;
        run("err_rst", v);
        run("post_rst", vecs[3]);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule
